// File: rtl/regwb_arbiter.sv
// Writeback arbiter: round-robin merge of ALU (A) and load (B) writebacks onto one
// registered register-file write port, plus a pending-write scoreboard for hazard stalls.
module regwb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [AW-1:0]     a_reg,
    input  logic [DW-1:0]     a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [AW-1:0]     b_reg,
    input  logic [DW-1:0]     b_data,
    output logic              b_ready,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_reg,
    input  logic [AW-1:0]     readreg1,
    input  logic [AW-1:0]     readreg2,
    output logic              stall,
    output logic              we,
    output logic [AW-1:0]     writereg,
    output logic [DW-1:0]     writedata,
    output logic [2**AW-1:0]  busy
);

    localparam int NR = 2**AW;

    typedef enum logic {GRANT_A, GRANT_B} grant_e;

    grant_e          last_q, last_d;
    logic [NR-1:0]   busy_q, busy_d;
    logic            we_q, we_d;
    logic [AW-1:0]   writereg_q, writereg_d;
    logic [DW-1:0]   writedata_q, writedata_d;

    logic            xfer_a, xfer_b, xfer;
    logic [AW-1:0]   xfer_reg;
    logic [DW-1:0]   xfer_data;

    // Contention goes to whichever side did not win last; a lone requester always wins.
    always_comb begin
        a_ready = a_valid && (!b_valid || last_q == GRANT_B);
        b_ready = b_valid && (!a_valid || last_q == GRANT_A);
    end

    always_comb begin
        xfer_a    = a_valid && a_ready;
        xfer_b    = b_valid && b_ready;
        xfer      = xfer_a || xfer_b;
        xfer_reg  = xfer_a ? a_reg  : b_reg;
        xfer_data = xfer_a ? a_data : b_data;
    end

    always_comb begin
        last_d = last_q;
        if (xfer_a) begin
            last_d = GRANT_A;
        end else if (xfer_b) begin
            last_d = GRANT_B;
        end

        we_d        = xfer && (xfer_reg != '0);
        writereg_d  = xfer ? xfer_reg  : writereg_q;
        writedata_d = xfer ? xfer_data : writedata_q;

        // Clear before set so a same-cycle issue to the retiring register stays pending.
        busy_d = busy_q;
        if (xfer && xfer_reg != '0) begin
            busy_d[xfer_reg] = 1'b0;
        end
        if (issue_valid && issue_reg != '0) begin
            busy_d[issue_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= GRANT_B;
            busy_q      <= '0;
            we_q        <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
        end else begin
            last_q      <= last_d;
            busy_q      <= busy_d;
            we_q        <= we_d;
            writereg_q  <= writereg_d;
            writedata_q <= writedata_d;
        end
    end

    always_comb begin
        stall = ((readreg1 != '0) && busy_q[readreg1]) ||
                ((readreg2 != '0) && busy_q[readreg2]);
    end

    assign we        = we_q;
    assign writereg  = writereg_q;
    assign writedata = writedata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed bench for regwb_arbiter: linear stimulus with hand-computed expectations.
module tb_regwb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, b_valid, issue_valid;
    logic [AW-1:0] a_reg, b_reg, issue_reg, readreg1, readreg2;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready, stall, we;
    logic [AW-1:0] writereg;
    logic [DW-1:0] writedata;
    logic [31:0]   busy;

    int vectors = 0;
    int miscompares = 0;

    regwb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .readreg1(readreg1), .readreg2(readreg2), .stall(stall),
        .we(we), .writereg(writereg), .writedata(writedata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_valid = 0; b_valid = 0; issue_valid = 0;
        a_reg = '0; b_reg = '0; issue_reg = '0; readreg1 = '0; readreg2 = '0;
        a_data = '0; b_data = '0;
        #3;
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_writereg", writereg, 0);
        chk("rst_writedata", writedata, 0);
        chk("rst_ready", {a_ready, b_ready}, 2'b00);
        chk("rst_stall", stall, 0);
        #9 rst_n = 1'b1;
        tick();

        // Contention from reset: A first, then B, back-to-back writes
        a_valid = 1; a_reg = 3; a_data = 32'h11;
        b_valid = 1; b_reg = 4; b_data = 32'h22;
        #1;
        chk("c1_ready", {a_ready, b_ready}, 2'b10);
        tick();
        chk("c2_wb", {we, 27'(writereg), writedata}, {1'b1, 27'd3, 32'h11});
        chk("c2_ready", {a_ready, b_ready}, 2'b01);
        tick();
        chk("c3_wb", {we, 27'(writereg), writedata}, {1'b1, 27'd4, 32'h22});
        chk("c3_ready", {a_ready, b_ready}, 2'b10);
        a_valid = 0; b_valid = 0;
        tick();
        chk("idle_hold", {we, 27'(writereg), writedata}, {1'b0, 27'd4, 32'h22});

        // Scoreboard set and stall until B retires reg 7
        issue_valid = 1; issue_reg = 7;
        tick();
        issue_valid = 0; readreg1 = 7;
        #1;
        chk("busy7_set", busy, 32'h80);
        chk("stall_rr1", stall, 1);
        readreg1 = 0; readreg2 = 7;
        #1;
        chk("stall_rr2", stall, 1);
        readreg2 = 0; readreg1 = 7;
        b_valid = 1; b_reg = 7; b_data = 32'h77;
        #1;
        chk("b7_ready", b_ready, 1);
        chk("stall_no_bypass", stall, 1);
        tick();
        b_valid = 0;
        #1;
        chk("busy7_clr", busy, 0);
        chk("stall_clr", stall, 0);
        chk("b7_wb", {we, 27'(writereg), writedata}, {1'b1, 27'd7, 32'h77});
        readreg1 = 0;

        // Issue to reg 0 is ignored; reg 0 transfer accepted but not written
        issue_valid = 1; issue_reg = 9;
        tick();
        issue_reg = 0;
        a_valid = 1; a_reg = 0; a_data = 32'hFFFFFFFF;
        #1;
        chk("r0_ready", a_ready, 1);
        readreg1 = 0;
        tick();
        issue_valid = 0; a_valid = 0;
        #1;
        chk("r0_we", we, 0);
        chk("r0_busy", busy, 32'h200);
        chk("r0_nostall", stall, 0);

        // Same-cycle issue and transfer to busy reg 5: stays busy
        issue_valid = 1; issue_reg = 5;
        tick();
        a_valid = 1; a_reg = 5; a_data = 32'h55;
        #1;
        chk("r5_busy_pre", busy, 32'h220);
        chk("r5_ready", a_ready, 1);
        tick();
        issue_valid = 0; a_valid = 0;
        #1;
        chk("r5_busy_post", busy, 32'h220);
        chk("r5_wb", {we, 27'(writereg), writedata}, {1'b1, 27'd5, 32'h55});

        // Asynchronous reset mid-cycle discards a pending transfer
        a_valid = 1; a_reg = 6; a_data = 32'h66;
        tick();
        chk("r6_we", we, 1);
        a_reg = 8; a_data = 32'h88;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wb", {we, 27'(writereg), writedata}, 60'd0);
        chk("arst_busy", busy, 0);
        a_valid = 0;
        #2 rst_n = 1'b1;
        tick();
        chk("arst_no_pulse", we, 0);

        // B alone, three consecutive transfers with changing data
        b_valid = 1; b_reg = 10; b_data = 32'hB1;
        #1;
        chk("bseq_ready0", {a_ready, b_ready}, 2'b01);
        tick();
        chk("bseq_wb1", {we, 27'(writereg), writedata}, {1'b1, 27'd10, 32'hB1});
        b_reg = 11; b_data = 32'hB2;
        #1;
        chk("bseq_ready1", {a_ready, b_ready}, 2'b01);
        tick();
        chk("bseq_wb2", {we, 27'(writereg), writedata}, {1'b1, 27'd11, 32'hB2});
        b_reg = 12; b_data = 32'hB3;
        #1;
        chk("bseq_ready2", {a_ready, b_ready}, 2'b01);
        tick();
        chk("bseq_wb3", {we, 27'(writereg), writedata}, {1'b1, 27'd12, 32'hB3});
        b_valid = 0;
        tick();
        chk("bseq_idle", we, 0);

        // Last grant was B, so A wins the next contention
        a_valid = 1; a_reg = 1; a_data = 32'hA1;
        b_valid = 1; b_reg = 2; b_data = 32'hB0;
        #1;
        chk("rr_after_b", {a_ready, b_ready}, 2'b10);
        a_valid = 0; b_valid = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
